// File: rtl/input_precision_selection.sv
// Precision reduction: zeroes the low-order bits of four signed fields based on format.
// Output is registered with 1-cycle latency; ena=0 holds the outputs and there is no backpressure.
module input_precision_selection #(
  parameter int W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [1:0]          format,
  input  logic signed [W-1:0] E_x_in,
  input  logic signed [W-1:0] E_y_in,
  input  logic signed [W-1:0] L_x_in,
  input  logic signed [W-1:0] L_y_in,
  output logic signed [W-1:0] E_x_out,
  output logic signed [W-1:0] E_y_out,
  output logic signed [W-1:0] L_x_out,
  output logic signed [W-1:0] L_y_out
);

  logic [W-1:0]        w_mask;
  logic signed [W-1:0] r_e_x;
  logic signed [W-1:0] r_e_y;
  logic signed [W-1:0] r_l_x;
  logic signed [W-1:0] r_l_y;

  // Format 2'b11 is reserved and behaves like full precision.
  always_comb begin
    w_mask = {W{1'b1}};
    case (format)
      2'b01:   w_mask = {{(W/2){1'b1}}, {(W/2){1'b0}}};
      2'b10:   w_mask = {{(W/4){1'b1}}, {(W-W/4){1'b0}}};
      default: w_mask = {W{1'b1}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e_x <= '0;
      r_e_y <= '0;
      r_l_x <= '0;
      r_l_y <= '0;
    end else if (ena) begin
      r_e_x <= E_x_in & w_mask;
      r_e_y <= E_y_in & w_mask;
      r_l_x <= L_x_in & w_mask;
      r_l_y <= L_y_in & w_mask;
    end
  end

  assign E_x_out = r_e_x;
  assign E_y_out = r_e_y;
  assign L_x_out = r_l_x;
  assign L_y_out = r_l_y;

endmodule

// File: tb/tb_input_precision_selection.sv
// Bench for input_precision_selection at W=4: directed vector table plus a random sweep,
// with expected outputs queued at drive time and popped one edge later.
module tb_input_precision_selection;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [1:0]        format;
  logic signed [3:0] E_x_in, E_y_in, L_x_in, L_y_in;
  logic signed [3:0] E_x_out, E_y_out, L_x_out, L_y_out;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  input_precision_selection #(.W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .format  (format),
    .E_x_in  (E_x_in),
    .E_y_in  (E_y_in),
    .L_x_in  (L_x_in),
    .L_y_in  (L_y_in),
    .E_x_out (E_x_out),
    .E_y_out (E_y_out),
    .L_x_out (L_x_out),
    .L_y_out (L_y_out)
  );

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [1:0] fmt;
    logic [3:0] ex, ey, lx, ly;
    logic [3:0] oex, oey, olx, oly;
  } vec_t;

  typedef struct {
    logic [3:0] ex, ey, lx, ly;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  exp_t last;

  function automatic logic [3:0] ref_mask(input logic [1:0] f, input logic [3:0] v);
    case (f)
      2'b01:   return (v >> 2) << 2;
      2'b10:   return (v >> 3) << 3;
      default: return v;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] f,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    rst_n  = r;
    ena    = e;
    format = f;
    E_x_in = a;
    E_y_in = b;
    L_x_in = c;
    L_y_in = d;
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL %s: scoreboard empty, got %b %b %b %b", tag, E_x_out, E_y_out, L_x_out, L_y_out);
    end else begin
      tests--;
      x = sb.pop_front();
      cmp({tag, ".E_x"}, E_x_out, x.ex);
      cmp({tag, ".E_y"}, E_y_out, x.ey);
      cmp({tag, ".L_x"}, L_x_out, x.lx);
      cmp({tag, ".L_y"}, L_y_out, x.ly);
      last = x;
    end
  endtask

  initial begin
    // rst, ena, fmt, inputs ex ey lx ly, expected ex ey lx ly
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 4'h7, 4'h9, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 4'h7, 4'h9, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 4'h7, 4'hF, 4'hA, 4'h3, 4'h4, 4'hC, 4'h8, 4'h0};
    vecs[3]  = '{1'b1, 1'b1, 2'b11, 4'h7, 4'h9, 4'h5, 4'hF, 4'h7, 4'h9, 4'h5, 4'hF};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 4'h7, 4'hF, 4'hA, 4'h6, 4'h0, 4'h8, 4'h8, 4'h0};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 4'h7, 4'h9, 4'h5, 4'hF, 4'h7, 4'h9, 4'h5, 4'hF};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 4'h5, 4'h3, 4'hC, 4'h1, 4'h5, 4'h3, 4'hC, 4'h1};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 4'hE, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'hC, 4'h1};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 4'hE, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'hC, 4'h1};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 4'hE, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'hC, 4'h1};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{1'b1, 1'b1, 2'b10, 4'h8, 4'h9, 4'hF, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst_n, vecs[i].ena, vecs[i].fmt, vecs[i].ex, vecs[i].ey, vecs[i].lx, vecs[i].ly);
      sb.push_back('{vecs[i].oex, vecs[i].oey, vecs[i].olx, vecs[i].oly});
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // Input changes between edges must not reach the outputs.
    drive(1'b1, 1'b1, 2'b00, 4'h1, 4'h2, 4'h3, 4'h4);
    #3;
    cmp("nocomb.E_x", E_x_out, last.ex);
    cmp("nocomb.L_y", L_y_out, last.ly);
    sb.push_back('{4'h1, 4'h2, 4'h3, 4'h4});
    @(posedge clk);
    #1;
    check_out("nocomb_edge");

    for (int n = 0; n < 20000; n++) begin
      logic       r, e;
      logic [1:0] f;
      logic [3:0] a, b, c, d;
      exp_t       x;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 3) != 0);
      f = 2'($urandom_range(0, 3));
      a = 4'($urandom);
      b = 4'($urandom);
      c = 4'($urandom);
      d = 4'($urandom);
      if (!r)      x = '{4'h0, 4'h0, 4'h0, 4'h0};
      else if (!e) x = last;
      else         x = '{ref_mask(f, a), ref_mask(f, b), ref_mask(f, c), ref_mask(f, d)};
      drive(r, e, f, a, b, c, d);
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/input_precision_selection.md
INPUT_PRECISION_SELECTION -- requirements
Module: input_precision_selection

Interface
REQ-001 The module SHALL have parameter W, default 64, giving the operand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 The module SHALL have input clk, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have input rst_n, 1 bit, reset that is synchronous and active-low.
REQ-004 The module SHALL have input ena, 1 bit, the clock enable for the output registers.
REQ-005 The module SHALL have input format, 2 bits, the precision select.
REQ-006 The module SHALL have inputs E_x_in, E_y_in, L_x_in and L_y_in, each signed W bits, as the operand pair fields.
REQ-007 The module SHALL have outputs E_x_out, E_y_out, L_x_out and L_y_out, each signed W bits, registered, holding the precision-reduced fields.

Function
REQ-008 Each output SHALL be the matching input with its low-order bits forced to 0 according to format; sign and upper bits pass unchanged.
REQ-009 For format=2'b00 (full precision), all W bits SHALL pass unchanged.
REQ-010 For format=2'b01 (half precision), the upper W/2 bits SHALL pass and the lower W/2 bits SHALL be 0.
REQ-011 For format=2'b10 (quarter precision), the upper W/4 bits SHALL pass and the lower 3W/4 bits SHALL be 0.
REQ-012 For format=2'b11 (reserved), the outputs SHALL be identical to format=2'b00.
REQ-013 The same mask SHALL apply to all four fields in the same cycle; the mask SHALL be computed from format sampled in the same cycle as the data.
REQ-014 Latency SHALL be 1 cycle: inputs sampled at rising edge N with ena=1 appear on the outputs after edge N.
REQ-015 When ena=0 and rst_n=1, all outputs SHALL hold their previous values.
REQ-016 There SHALL be no arithmetic, rounding or saturation; truncation is toward negative infinity for signed values by bit masking only.
REQ-017 There SHALL be no combinational path from any input to any output.

Reset
REQ-018 When rst_n=0 at a rising edge, all four outputs SHALL become 0 regardless of ena, format or data.
REQ-019 Reset SHALL take priority over ena; the first sampled data after reset is taken at the first edge with rst_n=1 and ena=1.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight value; outputs are 0 after that edge.

Verification (W=4)
REQ-021 Reset: with rst_n=0 and any inputs -> all outputs 4'b0000 after the edge; ena is ignored.
REQ-022 Full precision: format=00, E_x=0111, E_y=1001, L_x=0101, L_y=1111 with ena=1 -> after 1 cycle the outputs are 0111, 1001, 0101, 1111; the same inputs with format=11 give the same outputs.
REQ-023 Half precision: format=01, E_x=0111, E_y=1111 (-1), L_x=1010, L_y=0011 -> after 1 cycle the outputs are 0100, 1100 (-4), 1000, 0000.
REQ-024 Quarter precision: format=10, E_x=0111, E_y=1111, L_x=1010, L_y=0110 -> after 1 cycle the outputs are 0000, 1000 (-8), 1000, 0000.
REQ-025 Enable hold: load format=00 and E_x=0101, then set ena=0 and drive E_x=1110 for 3 cycles -> E_x_out stays 0101; after ena=1 the next edge gives 1110.
REQ-026 Exhaustive sweep: a counter steps all combinations of format and four 4-bit fields, 2^18 cycles -> each output matches the REQ-008..012 reference model one cycle later, with 0 mismatches.
